scr1_clk_ctrl_mc: RTL and testbench



---
 rtl/scr1_clkctl_pkg.sv | 11 +
 rtl/scr1_cg.sv | 13 +
 rtl/scr1_clkctl_chan.sv | 80 ++++++++
 rtl/scr1_clk_ctrl_mc.sv | 38 +++
 tb/tb_scr1_clk_ctrl_mc.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/scr1_clkctl_pkg.sv
// scr1_clkctl_pkg: shared channel-state type, channel limit and counter sizing for the clock controller
package scr1_clkctl_pkg;
  typedef enum logic [1:0] {CH_RUN, CH_DRAIN, CH_OFF, CH_WAKE} chan_state_e;
  localparam int SCR1_CLKCTL_NCH_MAX = 8;
  // Hysteresis and wake windows share one counter since a channel is never in both states.
  function automatic int cnt_width(input int hyst, input int wake);
    int m;
    m = hyst > wake ? hyst : wake;
    return m > 0 ? $clog2(m + 1) : 1;
  endfunction
endpackage

// File: rtl/scr1_cg.sv
// scr1_cg: glitch-free latch-based clock gate; enable captured while clk is low, test_mode forces it open
module scr1_cg (
  input  logic clk,
  input  logic clk_en,
  input  logic test_mode,
  output logic clk_out
);
  logic en_lat;
  always_latch begin
    if (!clk) en_lat = clk_en | test_mode;
  end
  assign clk_out = clk & en_lat;
endmodule

// File: rtl/scr1_clkctl_chan.sv
// scr1_clkctl_chan: one gated channel (RUN/DRAIN/OFF/WAKE FSM, shared counter, clock gate)
// DRAIN hysteresis exists only when SCR1_CLKCTRL_HYST_EN is defined.
module scr1_clkctl_chan
  import scr1_clkctl_pkg::*;
#(
  parameter int HYST_CYC = 4,
  parameter int WAKE_CYC = 2
) (
  input  logic clk,
  input  logic ctrl_rst_n,
  input  logic test_mode,
  input  logic sleep_req,
  input  logic wake_req,
  output logic clk_out,
  output logic clk_en,
  output logic ready
);
  localparam int CW = cnt_width(HYST_CYC, WAKE_CYC);
`ifdef SCR1_CLKCTRL_HYST_EN
  localparam logic [CW-1:0] HYST_LD = CW'(HYST_CYC > 0 ? HYST_CYC - 1 : 0);
`endif
  localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYC > 0 ? WAKE_CYC - 1 : 0);
  chan_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic go_sleep;
  assign go_sleep = sleep_req & ~wake_req;
  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state  <= CH_RUN;
      cnt    <= '0;
      clk_en <= 1'b1;
      ready  <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      clk_en <= state_nxt != CH_OFF;
      ready  <= state_nxt == CH_RUN || state_nxt == CH_DRAIN;
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt != '0 ? cnt - 1'b1 : cnt;
    case (state)
      CH_RUN: begin
        if (go_sleep) begin
`ifdef SCR1_CLKCTRL_HYST_EN
          state_nxt = HYST_CYC == 0 ? CH_OFF : CH_DRAIN;
          cnt_nxt   = HYST_LD;
`else
          state_nxt = CH_OFF;
          cnt_nxt   = '0;
`endif
        end
      end
`ifdef SCR1_CLKCTRL_HYST_EN
      CH_DRAIN: begin
        state_nxt = !go_sleep ? CH_RUN : cnt == '0 ? CH_OFF : CH_DRAIN;
        cnt_nxt   = !go_sleep ? '0 : cnt_nxt;
      end
`endif
      CH_OFF: begin
        if (wake_req) begin
          state_nxt = WAKE_CYC == 0 ? CH_RUN : CH_WAKE;
          cnt_nxt   = WAKE_LD;
        end
      end
      CH_WAKE: state_nxt = cnt == '0 ? CH_RUN : CH_WAKE;
      default: begin
        state_nxt = CH_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end
  scr1_cg i_cg (
    .clk       (clk),
    .clk_en    (clk_en),
    .test_mode (test_mode),
    .clk_out   (clk_out)
  );
endmodule

// File: rtl/scr1_clk_ctrl_mc.sv
// scr1_clk_ctrl_mc: multi-channel clock controller, NCH independent sleep/wake gated domains
// Define SCR1_CLKCTRL_HYST_EN to enable the idle-hysteresis DRAIN state.
module scr1_clk_ctrl_mc
  import scr1_clkctl_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int HYST_CYC = 4,
  parameter int WAKE_CYC = 2
) (
  input  logic           clk,
  input  logic           ctrl_rst_n,
  input  logic           test_mode,
  input  logic [NCH-1:0] sleep_req_i,
  input  logic [NCH-1:0] wake_req_i,
  output logic           clk_alw_on_o,
  output logic [NCH-1:0] clk_o,
  output logic [NCH-1:0] clk_en_o,
  output logic [NCH-1:0] ready_o,
  output logic           all_asleep_o
);
  assign clk_alw_on_o = clk;
  assign all_asleep_o = ~|clk_en_o;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    scr1_clkctl_chan #(
      .HYST_CYC (HYST_CYC),
      .WAKE_CYC (WAKE_CYC)
    ) i_chan (
      .clk        (clk),
      .ctrl_rst_n (ctrl_rst_n),
      .test_mode  (test_mode),
      .sleep_req  (sleep_req_i[i]),
      .wake_req   (wake_req_i[i]),
      .clk_out    (clk_o[i]),
      .clk_en     (clk_en_o[i]),
      .ready      (ready_o[i])
    );
  end
endmodule

// File: tb/tb_scr1_clk_ctrl_mc.sv
// tb_scr1_clk_ctrl_mc: randomized scoreboard bench for the multi-channel clock controller
module tb_scr1_clk_ctrl_mc;
  localparam int NCH = 2;
  localparam int HYST_CYC = 4;
  localparam int WAKE_CYC = 2;
`ifdef SCR1_CLKCTRL_HYST_EN
  localparam int H = HYST_CYC;
`else
  localparam int H = 0;
`endif
  typedef struct {
    logic [NCH-1:0] en;
    logic [NCH-1:0] rdy;
    logic [NCH-1:0] gclk;
    logic           asl;
  } exp_t;
  logic clk = 1'b0;
  logic ctrl_rst_n = 1'b1;
  logic test_mode = 1'b0;
  logic [NCH-1:0] sleep_req_i = '0;
  logic [NCH-1:0] wake_req_i = '0;
  logic clk_alw_on_o, all_asleep_o;
  logic [NCH-1:0] clk_o, clk_en_o, ready_o;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  // Reference: a channel gates after H+1 consecutive ready cycles with sleep&~wake,
  // and becomes ready WAKE_CYC cycles after the cycle its wake is accepted.
  bit m_awake[NCH];
  bit m_ready[NCH];
  int m_wleft[NCH];
  int m_streak[NCH];
  scr1_clk_ctrl_mc #(.NCH(NCH), .HYST_CYC(HYST_CYC), .WAKE_CYC(WAKE_CYC)) dut (
    .clk          (clk),
    .ctrl_rst_n   (ctrl_rst_n),
    .test_mode    (test_mode),
    .sleep_req_i  (sleep_req_i),
    .wake_req_i   (wake_req_i),
    .clk_alw_on_o (clk_alw_on_o),
    .clk_o        (clk_o),
    .clk_en_o     (clk_en_o),
    .ready_o      (ready_o),
    .all_asleep_o (all_asleep_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [NCH-1:0] m_en();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_awake[i];
    return v;
  endfunction
  function automatic logic [NCH-1:0] m_rdy();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_ready[i];
    return v;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_awake[i] = 1'b1;
      m_ready[i] = 1'b1;
      m_wleft[i] = 0;
      m_streak[i] = 0;
    end
  endtask
  task automatic apply(input logic [NCH-1:0] s, input logic [NCH-1:0] w, input logic tm);
    exp_t e;
    e.gclk = m_en() | {NCH{tm}};
    for (int i = 0; i < NCH; i++) begin
      if (!m_awake[i]) begin
        if (w[i]) begin
          m_awake[i] = 1'b1;
          m_wleft[i] = WAKE_CYC;
          m_ready[i] = WAKE_CYC == 0;
        end
      end else if (!m_ready[i]) begin
        m_wleft[i]--;
        if (m_wleft[i] == 0) m_ready[i] = 1'b1;
      end else begin
        m_streak[i] = (s[i] && !w[i]) ? m_streak[i] + 1 : 0;
        if (m_streak[i] == H + 1) begin
          m_awake[i] = 1'b0;
          m_ready[i] = 1'b0;
          m_streak[i] = 0;
        end
      end
    end
    e.en = m_en();
    e.rdy = m_rdy();
    e.asl = ~|e.en;
    q.push_back(e);
  endtask
  task automatic step(input logic [NCH-1:0] s, input logic [NCH-1:0] w, input logic tm);
    @(negedge clk);
    sleep_req_i = s;
    wake_req_i = w;
    test_mode = tm;
    apply(s, w, tm);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    sleep_req_i = '0;
    wake_req_i = '0;
    ctrl_rst_n = 1'b0;
    #1;
    chk("async_rst_en", 32'(clk_en_o), 32'({NCH{1'b1}}));
    chk("async_rst_rdy", 32'(ready_o), 32'({NCH{1'b1}}));
    chk("async_rst_asleep", 32'(all_asleep_o), 32'd0);
    #1 ctrl_rst_n = 1'b1;
    model_reset();
    apply('0, '0, test_mode);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("clk_en", 32'(clk_en_o), 32'(e.en));
      chk("ready", 32'(ready_o), 32'(e.rdy));
      chk("all_asleep", 32'(all_asleep_o), 32'(e.asl));
      chk("clk_o_high", 32'(clk_o), 32'(e.gclk));
      chk("clk_alw_on", 32'(clk_alw_on_o), 32'd1);
    end
  end
  initial begin
    logic [NCH-1:0] s_hold;
    logic tm;
    #1 ctrl_rst_n = 1'b0;
    #2;
    chk("rst_en", 32'(clk_en_o), 32'({NCH{1'b1}}));
    chk("rst_rdy", 32'(ready_o), 32'({NCH{1'b1}}));
    chk("rst_asleep", 32'(all_asleep_o), 32'd0);
    #1 ctrl_rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 8; k++) step(2'b01, '0, 1'b0);
    for (int k = 0; k < 6; k++) step(2'b11, '0, 1'b0);
    idle(2);
    step('0, 2'b01, 1'b0);
    idle(4);
    step('0, 2'b10, 1'b0);
    idle(3);
    for (int k = 0; k < 2; k++) step(2'b10, '0, 1'b0);
    idle(4);
    for (int k = 0; k < 6; k++) step(2'b01, 2'b01, 1'b0);
    for (int k = 0; k < 7; k++) step(2'b01, '0, 1'b0);
    for (int k = 0; k < 4; k++) step('0, '0, 1'b1);
    idle(2);
    step('0, 2'b01, 1'b0);
    pulse_reset();
    for (int k = 0; k < 2; k++) step(2'b10, '0, 1'b0);
    pulse_reset();
    idle(2);
    s_hold = '0;
    tm = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic [NCH-1:0] w;
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(7) == 0) s_hold[i] = ~s_hold[i];
        w[i] = $urandom_range(9) == 0;
      end
      if ($urandom_range(29) == 0) tm = ~tm;
      if ($urandom_range(299) == 0) pulse_reset();
      else step(s_hold, w, tm);
    end
    idle(1);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
